fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised instruction fetch queue for the superscalar core; the successor to the single-cycle top's direct PC-to-instruction-memory path.
- Owns the fetch PC and requests ISSUE_W instructions per cycle from instruction memory.
- Buffers fetched instructions with their PCs in a DEPTH-entry circular queue.
- Presents up to ISSUE_W oldest entries to decode. Supports redirect/flush on taken branch or jump, and misaligned redirect targets.

Parameters:
XLEN, 32, address/PC width
DEPTH, 4, queue entries; power of 2, >= 2*ISSUE_W
ISSUE_W, 2, instructions fetched/presented per cycle; legal values 1 or 2
RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
imem_addr  out  XLEN  fetch PC aligned down to 4*ISSUE_W bytes
imem_rdata  in  32*ISSUE_W  lane k = instruction at imem_addr+4k (combinational read)
imem_valid  in  1  imem_rdata valid this cycle; 0 = memory wait
redirect_valid  in  1  flush queue and restart fetch
redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored, treated as 0
deq_take  in  2  entries decode consumes this cycle, 0..ISSUE_W
out_instr  out  32*ISSUE_W  slot 0 = oldest entry
out_pc  out  XLEN*ISSUE_W  PC of each slot
out_valid  out  ISSUE_W  bit i = 1 when count > i
count  out  clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset, same edge, highest priority:
  - fetch PC = RESET_PC
  - head, tail and count = 0
  - out_valid = 0
  - imem_addr = RESET_PC aligned
  - out_instr and out_pc are don't-care while their out_valid bit is 0
- Lane offset: off = fetch_pc[clog2(ISSUE_W)+1:2]; 0 when ISSUE_W=1.
- Push count: pcnt = ISSUE_W - off.
- Enqueue condition: imem_valid && (DEPTH - count) >= pcnt.
  - count is the registered value; a same-cycle dequeue does not free space for push.
- On enqueue:
  - Lanes off..ISSUE_W-1 are written at tail in lane order, with PC = imem_addr + 4*lane.
  - tail += pcnt, modulo DEPTH, wraps.
  - fetch PC = imem_addr + 4*ISSUE_W, so the next fetch is aligned.
- No enqueue: fetch PC holds.
- Dequeue:
  - Effective take = min(deq_take, count, ISSUE_W). Values above that are clamped, never underflow.
  - head advances by take, modulo DEPTH.
- Enqueue and dequeue in the same cycle both apply: count_next = count + pushed - take.
- Outputs: registered state only. out_* reflect head..head+ISSUE_W-1, modulo DEPTH, combinationally from queue storage. Zero latency from storage; one cycle from imem_rdata to out_valid.
- Redirect (redirect_valid=1 and reset=0), next edge:
  - count = 0, head = tail = 0
  - fetch PC = {redirect_pc[XLEN-1:2], 2'b00}
  - Same-cycle enqueue and dequeue are discarded.
- Redirect and reset in the same cycle: reset wins.
- Full queue (count = DEPTH): no push, fetch PC holds, imem_rdata is ignored.
- Empty queue: out_valid = 0; deq_take is ignored.
- Fetch PC wraps modulo 2^XLEN.

Optional Feature:
- Macro FQ_PERF_EN.
- Defined: adds output perf_full_stall, 32 bits.
  - Increments each cycle imem_valid=1 and the enqueue condition is false.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by reset only; redirect does not clear it.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset with defaults -> imem_addr=0, count=0, out_valid=2'b00. Hold reset 3 cycles with imem_valid=1 -> count stays 0.
- Fill (imem_valid=1, deq_take=0):
  - After edge 1: count=2, out_pc={4,0}, imem_addr=8.
  - After edge 2: count=4, imem_addr=0x10.
  - After edge 3: count=4, imem_addr=0x10; with FQ_PERF_EN, perf_full_stall=1.
- Simultaneous push/pop from count=2 with deq_take=2 -> next count=2, out_pc={0xC,0x8}. Run 8 cycles; head/tail wrap with out_pc strictly increasing by 4.
- Redirect to 0x104 with count=4 and deq_take=2 in the same cycle:
  - Next: count=0, imem_addr=0x100.
  - Following edge: count=1, out_pc[0]=0x104, out_instr[0]=lane 1 data, imem_addr=0x108.
- Memory wait: imem_valid=0 for 3 cycles -> count unchanged, imem_addr unchanged. deq_take=2 with count=1 -> count=0, no underflow.
- reset=1 and redirect_valid=1 together -> imem_addr=RESET_PC, count=0.

Source files
------------

// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_if
//   Groups the fetch queue's instruction-memory and decode-side signals.
//
//   Parameters:
//     XLEN    - address / PC width
//     DEPTH   - queue entries (sets the width of count)
//     ISSUE_W - instructions fetched / presented per cycle (1 or 2)
//
//   Signals:
//     imem_addr      - fetch address, aligned down to 4*ISSUE_W bytes
//     imem_rdata     - lane k = instruction at imem_addr + 4k
//     imem_valid     - imem_rdata valid this cycle
//     redirect_valid - flush queue and restart fetch
//     redirect_pc    - new fetch PC (bits [1:0] ignored)
//     deq_take       - entries decode consumes this cycle
//     out_instr      - presented instructions, slot 0 = oldest
//     out_pc         - PC of each presented slot
//     out_valid      - bit i set when more than i entries are queued
//     count          - occupied entries
//
//   Modports:
//     slave  - the fetch queue itself
//     master - the environment (memory + decode + branch unit)
// ---------------------------------------------------------------------------
interface fetch_queue_if #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int ISSUE_W = 2
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]         imem_addr;
    logic [32*ISSUE_W-1:0]   imem_rdata;
    logic                    imem_valid;
    logic                    redirect_valid;
    logic [XLEN-1:0]         redirect_pc;
    logic [1:0]              deq_take;
    logic [32*ISSUE_W-1:0]   out_instr;
    logic [XLEN*ISSUE_W-1:0] out_pc;
    logic [ISSUE_W-1:0]      out_valid;
    logic [CW-1:0]           count;

    modport slave (
        output imem_addr,
        input  imem_rdata,
        input  imem_valid,
        input  redirect_valid,
        input  redirect_pc,
        input  deq_take,
        output out_instr,
        output out_pc,
        output out_valid,
        output count
    );

    modport master (
        input  imem_addr,
        output imem_rdata,
        output imem_valid,
        output redirect_valid,
        output redirect_pc,
        output deq_take,
        input  out_instr,
        input  out_pc,
        input  out_valid,
        input  count
    );
endinterface

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Instruction fetch queue. Owns the fetch PC, requests ISSUE_W aligned
//   instructions per cycle from instruction memory, buffers them with their
//   PCs in a DEPTH-entry circular queue and presents the oldest ISSUE_W
//   entries to decode. A redirect flushes the queue and restarts fetch at
//   the new PC; misaligned targets push only the lanes at or above the
//   target lane.
//
//   Ports:
//     clk             - clock, rising edge
//     reset           - synchronous active-high reset
//     bus (slave)     - fetch_queue_if: imem request/response, redirect,
//                       decode dequeue and presented entries
//     perf_full_stall - (FQ_PERF_EN only) saturating count of cycles where
//                       memory had data but the queue could not accept it
//
//   Optional feature macro: FQ_PERF_EN
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter int              ISSUE_W  = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    fetch_queue_if.slave        bus
`ifdef FQ_PERF_EN
    ,
    output logic [31:0]         perf_full_stall
`endif
);
    localparam int              PW         = $clog2(DEPTH);
    localparam int              CW         = PW + 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(4 * ISSUE_W - 1);
    localparam logic [XLEN-1:0] STRIDE     = XLEN'(4 * ISSUE_W);
    localparam logic [XLEN-1:0] WORD_MASK  = ~XLEN'(3);

    // Architectural state
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    // Queue storage (no reset; validity is tracked by count)
    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];

    logic [XLEN-1:0] fetch_base;
    logic            off;
    logic [CW-1:0]   pcnt;
    logic [CW-1:0]   free_slots;
    logic            enq;
    logic [CW-1:0]   take;

    logic [ISSUE_W-1:0] wr_en;
    logic [PW-1:0]      wr_idx  [ISSUE_W];
    logic [XLEN-1:0]    lane_pc [ISSUE_W];

    assign fetch_base    = fetch_pc_q & ALIGN_MASK;
    assign bus.imem_addr = fetch_base;

    // Lane of the fetch PC within the aligned fetch group; only the
    // dual-issue build can start mid-group.
    generate
        if (ISSUE_W == 2) begin : g_off2
            assign off = fetch_pc_q[2];
        end else begin : g_off1
            assign off = 1'b0;
        end
    endgenerate

    assign pcnt       = CW'(ISSUE_W) - CW'(off);
    // Space is judged on the registered count: a same-cycle dequeue does
    // not make room for this cycle's push.
    assign free_slots = CW'(DEPTH) - count_q;
    assign enq        = bus.imem_valid && (free_slots >= pcnt);

    // Effective dequeue: clamp to what is present and to the issue width.
    always_comb begin
        take = CW'(bus.deq_take);
        if (take > count_q) begin
            take = count_q;
        end
        if (take > CW'(ISSUE_W)) begin
            take = CW'(ISSUE_W);
        end
    end

    // Per-lane write enables and destinations. Lanes below the offset are
    // skipped, so lane gi lands at tail + (gi - off).
    generate
        for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_lane
            assign wr_en[gi]   = enq && !bus.redirect_valid && !reset &&
                                 ((gi != 0) || (off == 1'b0));
            assign wr_idx[gi]  = tail_q + PW'(gi) - PW'(off);
            assign lane_pc[gi] = fetch_base + XLEN'(4 * gi);
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int l = 0; l < ISSUE_W; l++) begin
            if (wr_en[l]) begin
                instr_mem[wr_idx[l]] <= bus.imem_rdata[l*32 +: 32];
                pc_mem[wr_idx[l]]    <= lane_pc[l];
            end
        end
    end

    // Next-state logic
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (bus.redirect_valid) begin
            // Flush discards any same-cycle push or pop.
            fetch_pc_d = bus.redirect_pc & WORD_MASK;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            head_d  = head_q + PW'(take);
            count_d = count_q - take;
            if (enq) begin
                fetch_pc_d = fetch_base + STRIDE;
                tail_d     = tail_q + PW'(pcnt);
                count_d    = count_q + pcnt - take;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Presented slots read straight out of storage, oldest first.
    generate
        for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_slot
            logic [PW-1:0] rd_idx;
            assign rd_idx                          = head_q + PW'(gi);
            assign bus.out_instr[gi*32 +: 32]      = instr_mem[rd_idx];
            assign bus.out_pc[gi*XLEN +: XLEN]     = pc_mem[rd_idx];
            assign bus.out_valid[gi]               = (count_q > CW'(gi));
        end
    endgenerate

    assign bus.count = count_q;

`ifdef FQ_PERF_EN
    // Memory offered data but the queue could not take it. Survives
    // redirects; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_full_stall <= '0;
        end else if (bus.imem_valid && !enq && (perf_full_stall != 32'hFFFF_FFFF)) begin
            perf_full_stall <= perf_full_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    localparam int XLEN    = 32;
    localparam int DEPTH   = 4;
    localparam int ISSUE_W = 2;

    logic clk;
    logic reset;

    int checks;
    int errors;

    fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH), .ISSUE_W(ISSUE_W)) bus ();

`ifdef FQ_PERF_EN
    logic [31:0] perf_full_stall;
`endif

    fetch_queue #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .ISSUE_W (ISSUE_W),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus)
`ifdef FQ_PERF_EN
        ,
        .perf_full_stall(perf_full_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: the word at address a is a fixed scramble of a.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd3) ^ 32'hC0DE_5A00;
    endfunction

    always_comb begin
        bus.imem_rdata[31:0]  = mem_word(bus.imem_addr);
        bus.imem_rdata[63:32] = mem_word(bus.imem_addr + 32'd4);
    end

    typedef struct {
        logic        rst;
        logic        iv;
        logic        rv;
        logic [31:0] rpc;
        logic [1:0]  dt;
        logic [2:0]  e_count;
        logic [31:0] e_addr;
        logic [1:0]  e_valid;
        logic [31:0] e_pc0;
        logic [31:0] e_pc1;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic check_state(input int idx, input logic [2:0] e_count, input logic [31:0] e_addr,
                               input logic [1:0] e_valid, input logic [31:0] e_pc0, input logic [31:0] e_pc1);
        chk("count", idx, 32'(bus.count), 32'(e_count));
        chk("imem_addr", idx, bus.imem_addr, e_addr);
        chk("out_valid", idx, 32'(bus.out_valid), 32'(e_valid));
        if (e_valid[0]) begin
            chk("out_pc0", idx, bus.out_pc[31:0], e_pc0);
            chk("out_instr0", idx, bus.out_instr[31:0], mem_word(e_pc0));
        end
        if (e_valid[1]) begin
            chk("out_pc1", idx, bus.out_pc[63:32], e_pc1);
            chk("out_instr1", idx, bus.out_instr[63:32], mem_word(e_pc1));
        end
    endtask

    initial begin
        logic [31:0] exp_pc0;
        checks = 0;
        errors = 0;

        //            rst   iv    rv    rpc            dt     cnt   addr           valid  pc0            pc1
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,         2'd0,  3'd0, 32'h0000_0000, 2'b00, 32'h0,         32'h0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,         2'd0,  3'd0, 32'h0000_0000, 2'b00, 32'h0,         32'h0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,         2'd0,  3'd0, 32'h0000_0000, 2'b00, 32'h0,         32'h0};
        // fill
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,         2'd0,  3'd2, 32'h0000_0008, 2'b11, 32'h0,         32'h4};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,         2'd0,  3'd4, 32'h0000_0010, 2'b11, 32'h0,         32'h4};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,         2'd0,  3'd4, 32'h0000_0010, 2'b11, 32'h0,         32'h4};
        // pop two, no memory
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,         2'd2,  3'd2, 32'h0000_0010, 2'b11, 32'h8,         32'hC};
        // simultaneous push/pop, wrapping head and tail
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,         2'd2,  3'd2, 32'h0000_0018, 2'b11, 32'h10,        32'h14};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,         2'd2,  3'd2, 32'h0000_0020, 2'b11, 32'h18,        32'h1C};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,         2'd2,  3'd2, 32'h0000_0028, 2'b11, 32'h20,        32'h24};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,         2'd2,  3'd2, 32'h0000_0030, 2'b11, 32'h28,        32'h2C};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,         2'd0,  3'd4, 32'h0000_0038, 2'b11, 32'h28,        32'h2C};
        // redirect with full queue and pending dequeue; low bits ignored
        vecs[12] = '{1'b0, 1'b1, 1'b1, 32'h0000_0106, 2'd2,  3'd0, 32'h0000_0100, 2'b00, 32'h0,         32'h0};
        // misaligned start: only lane 1 pushed
        vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h0,         2'd0,  3'd1, 32'h0000_0108, 2'b01, 32'h104,       32'h0};
        // memory wait
        vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,         2'd0,  3'd1, 32'h0000_0108, 2'b01, 32'h104,       32'h0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,         2'd0,  3'd1, 32'h0000_0108, 2'b01, 32'h104,       32'h0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,         2'd0,  3'd1, 32'h0000_0108, 2'b01, 32'h104,       32'h0};
        // take 2 with one present, then take 3 when empty
        vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,         2'd2,  3'd0, 32'h0000_0108, 2'b00, 32'h0,         32'h0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 32'h0,         2'd3,  3'd0, 32'h0000_0108, 2'b00, 32'h0,         32'h0};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 32'h0,         2'd0,  3'd2, 32'h0000_0110, 2'b11, 32'h108,       32'h10C};
        // take 3 clamped to 2 alongside a push; storage index wraps
        vecs[20] = '{1'b0, 1'b1, 1'b0, 32'h0,         2'd3,  3'd2, 32'h0000_0118, 2'b11, 32'h110,       32'h114};
        // reset and redirect together: reset wins
        vecs[21] = '{1'b1, 1'b1, 1'b1, 32'h0000_0200, 2'd0,  3'd0, 32'h0000_0000, 2'b00, 32'h0,         32'h0};
        // redirect near the top of the address space, then PC wraps
        vecs[22] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 2'd0,  3'd0, 32'hFFFF_FFF8, 2'b00, 32'h0,         32'h0};
        vecs[23] = '{1'b0, 1'b1, 1'b0, 32'h0,         2'd0,  3'd1, 32'h0000_0000, 2'b01, 32'hFFFF_FFFC, 32'h0};
        vecs[24] = '{1'b0, 1'b1, 1'b0, 32'h0,         2'd0,  3'd3, 32'h0000_0008, 2'b11, 32'hFFFF_FFFC, 32'h0};
        // one free slot, group needs two; same-cycle pop does not help
        vecs[25] = '{1'b0, 1'b1, 1'b0, 32'h0,         2'd1,  3'd2, 32'h0000_0008, 2'b11, 32'h0,         32'h4};

        reset              = 1'b1;
        bus.imem_valid     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.deq_take       = '0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset              = vecs[i].rst;
            bus.imem_valid     = vecs[i].iv;
            bus.redirect_valid = vecs[i].rv;
            bus.redirect_pc    = vecs[i].rpc;
            bus.deq_take       = vecs[i].dt;
            @(posedge clk);
            #1;
            check_state(i, vecs[i].e_count, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_pc0, vecs[i].e_pc1);
            $display("step %0d rst=%0d iv=%0d rv=%0d dt=%0d -> count=%0d addr=%h valid=%b",
                     i, reset, bus.imem_valid, bus.redirect_valid, bus.deq_take,
                     bus.count, bus.imem_addr, bus.out_valid);
`ifdef FQ_PERF_EN
            if (i == 5) begin
                chk("perf_full_stall", i, perf_full_stall, 32'd1);
            end
`endif
        end

        // Steady stream: push two and pop two every cycle for 8 cycles.
        exp_pc0 = 32'h0000_0008;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            reset              = 1'b0;
            bus.imem_valid     = 1'b1;
            bus.redirect_valid = 1'b0;
            bus.deq_take       = 2'd2;
            @(posedge clk);
            #1;
            check_state(100 + c, 3'd2, exp_pc0 + 32'd8, 2'b11, exp_pc0, exp_pc0 + 32'd4);
            $display("stream %0d count=%0d pc0=%h pc1=%h", c, bus.count, bus.out_pc[31:0], bus.out_pc[63:32]);
            exp_pc0 = exp_pc0 + 32'd8;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout got no-finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
